// File: rtl/match_result_serializer.sv
// Serializes the non-empty slots of a captured result vector into one beat per
// cycle over a valid/ready stream. An all-empty vector yields a single "none" beat.
module match_result_serializer #(
  parameter int N              = 8,
  parameter int log_N          = 3,
  parameter int elements_width = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [0:N*elements_width-1]     in,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [elements_width-1:0]       out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            out_none,
  output logic [log_N:0]                  match_count,
  output logic [1:0]                      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and payload holds while valid && !ready.

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, NONE = 2'd2} state_t;

  state_t                    state_q;
  logic [N-1:0]              mask_q;
  logic [elements_width-1:0] data_q [N];
  logic [elements_width-1:0] out_data_q;
  logic                      out_last_q;
  logic [log_N:0]            match_count_q;

  logic [elements_width-1:0] cap_elem [N];
  logic [N-1:0]              cap_mask;
  logic [N-1:0]              rem_mask;

  function automatic logic [log_N-1:0] lowest_idx(input logic [N-1:0] m);
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = log_N'(i);
    end
  endfunction

  function automatic logic [log_N:0] popcount(input logic [N-1:0] m);
    popcount = '0;
    for (int i = 0; i < N; i++) begin
      popcount = popcount + (log_N + 1)'(m[i]);
    end
  endfunction

  always_comb begin
    cap_mask = '0;
    for (int k = 0; k < N; k++) begin
      cap_elem[k] = in[k*elements_width +: elements_width];
      cap_mask[k] = |cap_elem[k];
    end
    // Mask with the currently emitted (lowest) slot removed.
    rem_mask = mask_q & (mask_q - N'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      match_count_q <= '0;
      for (int k = 0; k < N; k++) data_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N; k++) data_q[k] <= cap_elem[k];
            mask_q        <= cap_mask;
            match_count_q <= popcount(cap_mask);
            if (cap_mask != '0) begin
              state_q    <= EMIT;
              out_data_q <= cap_elem[lowest_idx(cap_mask)];
              out_last_q <= (popcount(cap_mask) == (log_N + 1)'(1));
            end else begin
              state_q    <= NONE;
              out_data_q <= '0;
              out_last_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            mask_q <= rem_mask;
            if (out_last_q) begin
              state_q    <= IDLE;
              out_data_q <= '0;
              out_last_q <= 1'b0;
            end else begin
              out_data_q <= data_q[lowest_idx(rem_mask)];
              out_last_q <= (popcount(rem_mask) == (log_N + 1)'(1));
            end
          end
        end
        NONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            out_last_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          out_data_q <= '0;
          out_last_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == EMIT) || (state_q == NONE);
  assign out_none    = (state_q == NONE);
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign match_count = match_count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/match_result_serializer.md
MATCH_RESULT_SERIALIZER -- requirements
Module: match_result_serializer

Interface
REQ-001 SHALL provide parameter: N, 8, number of result slots per input vector.
REQ-002 SHALL provide parameter: log_N, 3, log2(N).
REQ-003 SHALL provide parameter: elements_width, 4, width of each element.
REQ-004 SHALL provide port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port: in  input  [0:N*elements_width-1]  result vector; slot k = in[k*elements_width +: elements_width]; value 0 = empty slot.
REQ-007 SHALL provide port: in_valid  input  1  vector on in is valid.
REQ-008 SHALL provide port: in_ready  output  1  block can accept a vector.
REQ-009 SHALL provide port: out_data  output  elements_width  current non-empty element.
REQ-010 SHALL provide port: out_valid  output  1  out_data/out_last/out_none valid.
REQ-011 SHALL provide port: out_ready  input  1  downstream accepts current beat.
REQ-012 SHALL provide port: out_last  output  1  final beat of current vector.
REQ-013 SHALL provide port: out_none  output  1  vector held no non-empty slot.
REQ-014 SHALL provide port: match_count  output  log_N+1  number of non-empty slots in the held vector.

Function
REQ-015 SHALL implement three states: IDLE, EMIT, NONE.
REQ-016 In IDLE, in_ready SHALL be 1; in EMIT and NONE, in_ready SHALL be 0.
REQ-017 On a clock edge with in_valid=1 in IDLE, the block SHALL capture in, build a slot mask (bit k = slot k non-zero) and latch match_count = popcount(mask).
REQ-018 After capture, next state SHALL be EMIT if the mask is non-zero, else NONE.
REQ-019 In EMIT, out_valid SHALL be 1 and out_data SHALL be the captured element of the lowest-index set mask bit.
REQ-020 In EMIT, out_last SHALL be 1 exactly when one mask bit remains; out_none SHALL be 0.
REQ-021 On an EMIT edge with out_ready=1, the emitted slot's mask bit SHALL clear; if out_last was 1, next state SHALL be IDLE.
REQ-022 With out_ready=0, out_data, out_last, the mask and the state SHALL hold unchanged.
REQ-023 In NONE, out_valid=1, out_none=1, out_last=1, out_data=0; on out_ready=1, next state SHALL be IDLE.
REQ-024 In IDLE, out_valid, out_last and out_none SHALL be 0, and out_data SHALL be 0.
REQ-025 The first beat SHALL be valid the cycle after capture; beats SHALL then issue one per cycle while out_ready=1.
REQ-026 A new vector SHALL NOT be accepted in the cycle the last beat is consumed, giving one IDLE cycle between vectors.
REQ-027 in_valid outside IDLE SHALL be ignored; nothing is captured or queued.
REQ-028 match_count SHALL hold its latched value from capture until the next capture; it SHALL be 0 after reset.
REQ-029 All outputs SHALL derive only from registered state, with no combinational path from in or in_valid to any output.
REQ-030 Element value 0 SHALL never be emitted in EMIT; this matches the empty-slot encoding of the upstream BMNC stage.

Reset
REQ-031 Reset SHALL asynchronously force state IDLE, clear the mask and the held vector, set match_count=0, out_valid=0, out_last=0, out_none=0 and out_data=0.
REQ-032 Reset asserted mid-EMIT or mid-NONE SHALL abort the vector with no further beats; in_ready SHALL be 1 on the first edge after reset is released.

Verification
REQ-033 SHALL test N=8, elements_width=4: slots {0,3,0,0,7,0,0,1}, out_ready=1 -> beats 3,7,1 on three consecutive cycles, out_last only on 1, match_count=3, in_ready returns 1 after the last beat.
REQ-034 SHALL test an all-zero vector -> exactly one beat with out_none=1, out_last=1, out_data=0, and match_count=0.
REQ-035 SHALL test a full vector {1,2,3,4,5,6,7,8} -> eight contiguous beats 1..8, out_last on 8, match_count=8 (4'b1000).
REQ-036 SHALL test backpressure on slots {0,3,0,0,7,0,0,1}: out_ready=0 for 3 cycles at the first beat -> out_data holds 3 with out_valid=1, then 3,7,1 follow.
REQ-037 SHALL test reset after the first beat is consumed -> outputs immediately 0, match_count=0, and the next vector is accepted normally.
REQ-038 SHALL test in_valid=1 with a different vector during EMIT -> that vector is ignored and the in-flight sequence is unchanged.
